// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// sprite_pkg : shared constants and types for the sprite scheduler
// Revision   : 1.0
// ============================================================================
package sprite_pkg;

    localparam int NUM_SPRITES = 4;
    localparam int SPR_SIZE    = 16;
    localparam int COORD_W     = 10;
    localparam int IDX_W       = $clog2(NUM_SPRITES);
    localparam int LOC_W       = $clog2(SPR_SIZE);

    localparam logic [2:0] COL_TRANSPARENT = 3'b000;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               en;
    } sprite_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } commit_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_prio_arb.sv
`default_nettype none
// ============================================================================
// sprite_prio_arb : fixed-priority arbiter, lowest set index wins
// Revision        : 1.0
// ============================================================================
module sprite_prio_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     hit,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        // Walk downwards so the lowest hit index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_scheduler.sv
`default_nettype none
// ============================================================================
// sprite_scheduler : shadow/live sprite banks, frame-start commit and a
//                    two-stage pixel compositing pipeline over shared ROMs
// Revision         : 1.0
// ============================================================================
module sprite_scheduler
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_tick,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic               video_on,
    input  logic               frame_start,
    input  logic [2:0]         bg_col,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [IDX_W-1:0]   upd_idx,
    input  logic [COORD_W-1:0] upd_x,
    input  logic [COORD_W-1:0] upd_y,
    input  logic               upd_en,
    output logic [IDX_W-1:0]   rom_sel,
    output logic [LOC_W-1:0]   rom_lx,
    output logic [LOC_W-1:0]   rom_ly,
    input  logic [2:0]         rom_col,
    output logic [2:0]         pix_col,
    output logic               pix_valid
);

    commit_state_t                  state_q, state_d;
    logic [IDX_W-1:0]               cnt_q, cnt_d;
    logic                           run_q;
    sprite_t [NUM_SPRITES-1:0]      shadow_q, shadow_d;
    sprite_t [NUM_SPRITES-1:0]      live_q, live_d;

    logic [IDX_W-1:0]               rom_sel_q, rom_sel_d;
    logic [LOC_W-1:0]               rom_lx_q, rom_lx_d;
    logic [LOC_W-1:0]               rom_ly_q, rom_ly_d;
    logic                           hit_q, hit_d;
    logic                           von_q, von_d;
    logic [2:0]                     pix_col_q, pix_col_d;
    logic                           pix_valid_q, pix_valid_d;

    logic [COORD_W:0]               dx [NUM_SPRITES];
    logic [COORD_W:0]               dy [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]         hit_vec;
    logic                           arb_any;
    logic [IDX_W-1:0]               arb_idx;

    // run_q keeps upd_ready low while reset is asserted and for the first clk after.
    assign upd_ready = run_q && (state_q == ST_IDLE);

    // A negative difference sets the top bit, so one upper-bits-zero test covers 0 <= d < SPR_SIZE.
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
        assign dx[gi]      = {1'b0, px} - {1'b0, live_q[gi].x};
        assign dy[gi]      = {1'b0, py} - {1'b0, live_q[gi].y};
        assign hit_vec[gi] = live_q[gi].en
                          && (dx[gi][COORD_W:LOC_W] == '0)
                          && (dy[gi][COORD_W:LOC_W] == '0);
    end

    sprite_prio_arb #(
        .N     (NUM_SPRITES),
        .IDX_W (IDX_W)
    ) u_arb (
        .hit (hit_vec),
        .any (arb_any),
        .idx (arb_idx)
    );

    always_comb begin
        shadow_d = shadow_q;
        live_d   = live_q;
        state_d  = state_q;
        cnt_d    = cnt_q;

        if (upd_valid && upd_ready) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (upd_idx == IDX_W'(i)) begin
                    shadow_d[i] = '{x: upd_x, y: upd_y, en: upd_en};
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_COPY;
                    cnt_d   = '0;
                end
            end
            ST_COPY: begin
                live_d[cnt_q] = shadow_q[cnt_q];
                if (cnt_q == IDX_W'(NUM_SPRITES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rom_sel_d   = rom_sel_q;
        rom_lx_d    = rom_lx_q;
        rom_ly_d    = rom_ly_q;
        hit_d       = hit_q;
        von_d       = von_q;
        pix_col_d   = pix_col_q;
        pix_valid_d = pix_valid_q;

        if (pix_tick) begin
            hit_d = arb_any;
            von_d = video_on;
            if (arb_any) begin
                rom_sel_d = arb_idx;
                rom_lx_d  = dx[arb_idx][LOC_W-1:0];
                rom_ly_d  = dy[arb_idx][LOC_W-1:0];
            end
            pix_valid_d = von_q;
            if (!von_q) begin
                pix_col_d = '0;
            end else if (hit_q && (rom_col != COL_TRANSPARENT)) begin
                pix_col_d = rom_col;
            end else begin
                pix_col_d = bg_col;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            shadow_q    <= '0;
            live_q      <= '0;
            rom_sel_q   <= '0;
            rom_lx_q    <= '0;
            rom_ly_q    <= '0;
            hit_q       <= 1'b0;
            von_q       <= 1'b0;
            pix_col_q   <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= 1'b1;
            shadow_q    <= shadow_d;
            live_q      <= live_d;
            rom_sel_q   <= rom_sel_d;
            rom_lx_q    <= rom_lx_d;
            rom_ly_q    <= rom_ly_d;
            hit_q       <= hit_d;
            von_q       <= von_d;
            pix_col_q   <= pix_col_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign rom_sel   = rom_sel_q;
    assign rom_lx    = rom_lx_q;
    assign rom_ly    = rom_ly_q;
    assign pix_col   = pix_col_q;
    assign pix_valid = pix_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_scheduler.sv
`default_nettype none
// ============================================================================
// tb_sprite_scheduler : directed self-checking bench for sprite_scheduler
// Revision            : 1.0
// ============================================================================
module tb_sprite_scheduler;
    import sprite_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               pix_tick;
    logic [COORD_W-1:0] px, py;
    logic               video_on;
    logic               frame_start;
    logic [2:0]         bg_col;
    logic               upd_valid;
    logic               upd_ready;
    logic [IDX_W-1:0]   upd_idx;
    logic [COORD_W-1:0] upd_x, upd_y;
    logic               upd_en;
    logic [IDX_W-1:0]   rom_sel;
    logic [LOC_W-1:0]   rom_lx, rom_ly;
    logic [2:0]         rom_col;
    logic [2:0]         pix_col;
    logic               pix_valid;

    int n_checks = 0;
    int n_errors = 0;

    sprite_scheduler u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_tick    (pix_tick),
        .px          (px),
        .py          (py),
        .video_on    (video_on),
        .frame_start (frame_start),
        .bg_col      (bg_col),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_idx     (upd_idx),
        .upd_x       (upd_x),
        .upd_y       (upd_y),
        .upd_en      (upd_en),
        .rom_sel     (rom_sel),
        .rom_lx      (rom_lx),
        .rom_ly      (rom_ly),
        .rom_col     (rom_col),
        .pix_col     (pix_col),
        .pix_valid   (pix_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int x, input int y, input logic vo);
        px       = COORD_W'(x);
        py       = COORD_W'(y);
        video_on = vo;
        pix_tick = 1'b1;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
    endtask

    task automatic upd(input int idx, input int x, input int y, input logic en);
        upd_idx   = IDX_W'(idx);
        upd_x     = COORD_W'(x);
        upd_y     = COORD_W'(y);
        upd_en    = en;
        upd_valid = 1'b1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    // frame_start already applied by caller; waits out the copy and checks its length.
    task automatic finish_commit(input string tag);
        int n;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        upd_valid   = 1'b0;
        n = 0;
        while (!upd_ready && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        check_eq(tag, n, 4);
    endtask

    task automatic commit(input string tag);
        frame_start = 1'b1;
        finish_commit(tag);
    endtask

    // Two ticks on the same pixel: stage-1 result, then composited colour.
    task automatic pix_at(input string tag, input int x, input int y,
                          input int e_sel, input int e_lx, input int e_ly, input int e_col);
        tick(x, y, 1'b1);
        check_eq({tag, "_sel"}, rom_sel, e_sel);
        check_eq({tag, "_lx"},  rom_lx,  e_lx);
        check_eq({tag, "_ly"},  rom_ly,  e_ly);
        tick(x, y, 1'b1);
        check_eq({tag, "_col"}, pix_col, e_col);
        check_eq({tag, "_vld"}, pix_valid, 1);
    endtask

    initial begin
        rst_n = 1'b0; pix_tick = 1'b0; px = '0; py = '0; video_on = 1'b0;
        frame_start = 1'b0; bg_col = 3'b010; upd_valid = 1'b0; upd_idx = '0;
        upd_x = '0; upd_y = '0; upd_en = 1'b0; rom_col = 3'b101;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", upd_ready, 0);
        check_eq("rst_col",   pix_col,   0);
        check_eq("rst_vld",   pix_valid, 0);
        check_eq("rst_sel",   rom_sel,   0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_ready", upd_ready, 1);

        // basic hit
        upd(0, 32, 48, 1'b1);
        commit("copy_len1");
        pix_at("basic", 35, 50, 0, 3, 2, 5);

        // overlap, transparent top sprite shows background
        upd(0, 100, 100, 1'b1);
        upd(2, 104, 100, 1'b1);
        commit("copy_len2");
        rom_col = 3'b000;
        pix_at("ovl_transp", 106, 101, 0, 6, 1, 2);
        rom_col = 3'b110;
        pix_at("ovl_lower", 117, 101, 2, 13, 1, 6);

        // boundaries
        upd(0, 630, 470, 1'b1);
        upd(1, 1020, 0, 1'b1);
        upd(2, 0, 0, 1'b0);
        commit("copy_len3");
        pix_at("edge_in", 639, 475, 0, 9, 5, 6);
        pix_at("edge_out", 646, 475, 0, 9, 5, 2);
        pix_at("nowrap", 2, 3, 0, 9, 5, 2);
        pix_at("far_right", 1023, 3, 1, 3, 3, 6);

        // tearing: shadow update is invisible until commit
        upd(1, 200, 200, 1'b1);
        pix_at("tear_old", 205, 205, 1, 3, 3, 2);
        commit("copy_len4");
        pix_at("tear_new", 205, 205, 1, 5, 5, 6);

        // update beat coincident with frame_start is included
        upd_idx = 2'd1; upd_x = 10'd300; upd_y = 10'd300; upd_en = 1'b1;
        upd_valid = 1'b1;
        frame_start = 1'b1;
        finish_commit("copy_len5");
        pix_at("same_clk", 303, 304, 1, 3, 4, 6);

        // stall: outputs frozen while pix_tick is low
        px = 10'd0; py = 10'd0; video_on = 1'b0; rom_col = 3'b111; bg_col = 3'b001;
        repeat (5) @(posedge clk);
        #1;
        check_eq("stall_sel", rom_sel, 1);
        check_eq("stall_lx",  rom_lx,  3);
        check_eq("stall_ly",  rom_ly,  4);
        check_eq("stall_col", pix_col, 6);
        check_eq("stall_vld", pix_valid, 1);

        // blanking
        tick(0, 0, 1'b0);
        tick(0, 0, 1'b0);
        check_eq("blank_vld", pix_valid, 0);
        check_eq("blank_col", pix_col,   0);

        // reset during copy
        bg_col = 3'b010; rom_col = 3'b110;
        pix_at("pre_rst", 303, 304, 1, 3, 4, 6);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", upd_ready, 0);
        check_eq("mid_rst_col",   pix_col,   0);
        check_eq("mid_rst_vld",   pix_valid, 0);
        check_eq("mid_rst_sel",   rom_sel,   0);
        check_eq("mid_rst_lx",    rom_lx,    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_ready", upd_ready, 1);
        commit("copy_len6");
        pix_at("cleared", 303, 304, 0, 0, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Shares the per-sprite 16x16 colour-mask ROMs among NUM_SPRITES on-screen objects (players, bombs) and composites the result onto the VGA pixel stream.
- For every pixel it finds the highest-priority sprite covering it and drives that ROM's local coordinates, then merges the returned 3-bit colour with the background.
- Sprite positions come from game logic through a shadow bank. The shadow bank is committed to the live bank only at frame start, so sprites never tear mid-frame.
- Sits between the VGA timing generator, the game-logic FSMs and the sprite mask ROMs.

Parameters:
- NUM_SPRITES, 4, number of sprites; index 0 has highest priority.
- SPR_SIZE, 16, sprite edge in pixels; must be a power of two.
- COORD_W, 10, width of screen coordinates.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_tick  in  1  pixel enable, one clk wide; the pixel pipeline advances only on this.
- px, py  in  COORD_W each  current pixel coordinate from the VGA timing generator.
- video_on  in  1  high inside the visible area.
- frame_start  in  1  one-clk pulse at the start of vertical blank.
- bg_col  in  3  background colour for the current pixel.
- upd_valid  in  1  position update request.
- upd_ready  out  1  update accepted when upd_valid and upd_ready are both high.
- upd_idx  in  clog2(NUM_SPRITES)  sprite to update.
- upd_x, upd_y  in  COORD_W each  new top-left corner.
- upd_en  in  1  sprite visible flag.
- rom_sel  out  clog2(NUM_SPRITES)  ROM selected for the current lookup.
- rom_lx, rom_ly  out  clog2(SPR_SIZE) each  local coordinates driven to the ROM.
- rom_col  in  3  colour returned by the selected ROM, combinational within the same pix_tick period.
- pix_col  out  3  composited pixel colour {green, blue, red}.
- pix_valid  out  1  high when pix_col corresponds to a visible pixel.

Behaviour:
Reset: every output and register is 0, all live and shadow enables are cleared, and the FSM is in IDLE.

Update handshake:
- Shadow registers are written on an upd_valid && upd_ready beat.
- Updates with upd_idx >= NUM_SPRITES are accepted and dropped.
- Multiple beats to the same index within a frame: the last beat wins.

Commit FSM:
- IDLE: upd_ready = 1. On frame_start, go to COPY with cnt = 0.
- If an update beat and frame_start occur in the same clk, the update lands in the shadow bank first and is included in the commit.
- COPY: upd_ready = 0. Copy shadow[cnt] to live[cnt] each clk. After cnt = NUM_SPRITES-1, return to IDLE. The commit takes exactly NUM_SPRITES clks.
- A frame_start received during COPY is ignored.

Pixel pipeline (advances on pix_tick only; stalls otherwise):
- Stage 1 hit test, per sprite i: dx = px - x_i and dy = py - y_i, computed COORD_W+1 bits wide. Hit when en_i is set and 0 <= dx < SPR_SIZE and 0 <= dy < SPR_SIZE.
- Sprites partially off the right or bottom edge clip naturally; no wrap-around.
- The fixed-priority arbiter picks the lowest hit index. rom_sel, rom_lx and rom_ly are registered from dx, dy, along with hit and video_on.
- With no hit, rom_sel, rom_lx and rom_ly hold their previous values.
- Stage 2: pix_col = (hit && rom_col != 0) ? rom_col : bg_col. Colour 000 is transparent, so a transparent pixel of a higher-priority sprite shows background, not a lower sprite.
- pix_valid = the registered video_on. When video_on was 0, pix_col = 0.
- Latency: pix_col and pix_valid appear 2 pix_ticks after px, py are sampled.

Reset mid-operation: the pipeline flushes and pix_col = 0. Both banks clear, so no sprite is drawn until the next update and commit.

Decomposition:
- Package sprite_pkg holds NUM_SPRITES, SPR_SIZE, COORD_W, the constant COL_TRANSPARENT = 3'b000, and the struct sprite_t {x, y, en}.
- Sub-module sprite_prio_arb: combinational NUM_SPRITES-bit hit vector to {any, idx}, lowest index wins.

Test Plan:
- Reset, then drive sprite 0 to (32,48) with en=1 and pulse frame_start. Expect upd_ready low for exactly 4 clks. At px=35, py=50, expect rom_sel=0, rom_lx=3, rom_ly=2, and pix_col = rom_col 2 ticks later.
- Overlap: sprite 0 at (100,100) and sprite 2 at (104,100). At px=106, py=101, expect rom_sel=0. With rom_col=000, expect pix_col=bg_col, not sprite 2.
- Boundary: sprite at (630,470). px=639 gives a hit with lx=9. px=(sprite x)+16 gives no hit. A sprite at x=1020 must not hit at px=2.
- Tearing: update sprite 1 mid-frame. Pixels keep the old position until after the next frame_start commit. An update beat in the same clk as frame_start is included in that commit.
- pix_tick held low for 5 clks: outputs are frozen. With video_on=0, expect pix_valid=0 and pix_col=0.
- Assert rst_n low during COPY: all outputs read 0 immediately, and after release the FSM is in IDLE with upd_ready=1.
